// File: rtl/tx_mod_pkg.sv
// Shared constants, sample type and offset-binary helper for the transmit sample modulator.
package tx_mod_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 13;
  localparam int unsigned DEFAULT_RATE       = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask on lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic signed [DEFAULT_WIDTH-1:0] sample_t;

  // Two's complement to offset binary; the mapping is its own inverse
  function automatic logic [DEFAULT_WIDTH-1:0] to_offset(input sample_t s);
    return {~s[DEFAULT_WIDTH-1], s[DEFAULT_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/tx_sample_modulator_if.sv
// Write-only SPI link from the STM32 into the sample modulator.
interface tx_sample_modulator_if;
  logic sck;
  logic mosi;
  logic nss;

  modport master (output sck, output mosi, output nss);
  modport slave  (input  sck, input  mosi, input  nss);
endinterface

// File: rtl/tx_sample_fifo.sv
// Synchronous sample FIFO; a push into a full FIFO succeeds only when a pop frees a slot that cycle.
module tx_sample_fifo
  import tx_mod_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic                   drop_c,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c    = (level == LVL_W'(DEPTH));
  assign empty_c   = (level == '0);
  assign do_pop    = pop && !empty_c;
  assign do_push   = push && (!full_c || do_pop);
  assign drop_c    = push && !do_push;
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage needs no reset; pointers and level define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tx_sample_modulator.sv
// SPI sample receiver, FIFO, RATE-clock sample hold and first-order sigma-delta modulator.
// Optional TX_DITHER_EN adds LFSR dither (one LSB) to the modulator input.
module tx_sample_modulator
  import tx_mod_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned RATE       = DEFAULT_RATE,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  tx_sample_modulator_if.slave        spi,
  input  logic                        enable,
  output logic                        sd_out,
  output logic                        underrun,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned CNT_W = $clog2(RATE);
  localparam int unsigned BIT_W = $clog2(WIDTH);

  logic [1:0]       sck_sync;
  logic [1:0]       mosi_sync;
  logic [1:0]       nss_sync;
  logic             sck_d;
  logic             sck_rise;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_word;
  logic             rx_last;
  logic             rx_push;
  logic [CNT_W-1:0] hold_cnt;
  logic             wrap;
  logic [WIDTH-1:0] held;
  logic [WIDTH-1:0] fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] u_mod;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  // Two-flop synchronizers, reset to the idle bus state
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      nss_sync  <= 2'b11;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi.sck};
      mosi_sync <= {mosi_sync[0], spi.mosi};
      nss_sync  <= {nss_sync[0], spi.nss};
      sck_d     <= sck_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] && !sck_d;
  assign rx_word  = {rx_shift, mosi_sync[1]};
  assign rx_last  = (bit_cnt == BIT_W'(WIDTH - 1));
  assign rx_push  = sck_rise && !nss_sync[1] && rx_last;

  // Bit receiver; nss high drops any partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (nss_sync[1]) begin
      bit_cnt  <= '0;
    end else if (sck_rise) begin
      rx_shift <= rx_word[WIDTH-2:0];
      bit_cnt  <= rx_last ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  tx_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .pop       (wrap),
    .wr_data   (rx_word),
    .rd_data_c (fifo_rd),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .drop_c    (fifo_drop),
    .level     (fifo_level)
  );

  assign wrap = enable && (hold_cnt == CNT_W'(RATE - 1));

  // Sample hold: reload from the FIFO on wrap, mid-scale when idle or starved
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      held     <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      underrun <= wrap && fifo_empty;
      overflow <= fifo_drop;
      if (!enable) begin
        hold_cnt <= '0;
        held     <= '0;
      end else if (wrap) begin
        hold_cnt <= '0;
        held     <= fifo_empty ? '0 : fifo_rd;
      end else begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

  assign u = {~held[WIDTH-1], held[WIDTH-2:0]};

`ifdef TX_DITHER_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

  // Saturate so full-scale input cannot wrap to zero density
  assign u_mod = (&u) ? u : u + WIDTH'(lfsr[0]);
`else
  assign u_mod = u;
`endif

  assign sum = {1'b0, acc} + {1'b0, u_mod};

  // First-order sigma-delta: carry out of the accumulator is the bitstream
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      sd_out <= 1'b0;
    end else begin
      acc    <= sum[WIDTH-1:0];
      sd_out <= sum[WIDTH];
    end
  end

endmodule

// File: tb/tb_tx_sample_modulator.sv
// Directed bench for tx_sample_modulator: one RATE=32 instance and one RATE=64 instance sharing the SPI bus.
module tb_tx_sample_modulator;
  import tx_mod_pkg::*;

  logic       clk = 1'b0;
  logic       rst1, rst2;
  logic       enable1, enable2;
  logic       sd_out1, underrun1, overflow1;
  logic       sd_out2, underrun2, overflow2;
  logic [2:0] level1, level2;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_cnt  = 0;
  int unr_cnt  = 0;

  tx_sample_modulator_if spi_if ();

  always #5 clk = ~clk;

  tx_sample_modulator u_dut (
    .clk        (clk),
    .rst        (rst1),
    .spi        (spi_if),
    .enable     (enable1),
    .sd_out     (sd_out1),
    .underrun   (underrun1),
    .overflow   (overflow1),
    .fifo_level (level1)
  );

  // Slower hold so a clk/4 SPI link can keep its FIFO fed
  tx_sample_modulator #(.RATE(64)) u_dut_long (
    .clk        (clk),
    .rst        (rst2),
    .spi        (spi_if),
    .enable     (enable2),
    .sd_out     (sd_out2),
    .underrun   (underrun2),
    .overflow   (overflow2),
    .fifo_level (level2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (overflow1 === 1'b1) ovf_cnt++;
    if (underrun1 === 1'b1) unr_cnt++;
  end

  function automatic logic [12:0] word_k(input int k);
    return to_offset(sample_t'(13'(k * 256)));
  endfunction

  // Mode-0 word at sck = clk/4, MSB first; optionally checks push latency on the last bit
  task automatic spi_word(input logic [12:0] w, input int nbits, input bit chk_lat);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      spi_if.sck  = 1'b0;
      spi_if.mosi = w[12-i];
      @(negedge clk);
      @(negedge clk);
      spi_if.sck = 1'b1;
      if (chk_lat && i == nbits - 1) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lat_before_push", level1, 0);
        @(posedge clk); #1;
        check("lat_push_3clk", level1, 1);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    spi_if.sck = 1'b0;
    repeat (4) @(negedge clk);
    spi_if.nss = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_dut1();
    @(negedge clk);
    rst1    = 1'b1;
    enable1 = 1'b0;
    @(negedge clk);
    rst1    = 1'b0;
    ovf_cnt = 0;
    unr_cnt = 0;
  endtask

  task automatic measure(output int ones);
    ones = 0;
    repeat (32) begin
      @(posedge clk); #1;
      ones += int'(sd_out1);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ones;
    int first_unr;
    int unr;
    int ovf;
    bit seen;
    int exp4 [4];
    int exp6 [5];

    spi_if.sck  = 1'b0;
    spi_if.mosi = 1'b0;
    spi_if.nss  = 1'b1;
    rst1 = 1'b1; rst2 = 1'b1;
    enable1 = 1'b1; enable2 = 1'b0;

    // Reset values, then idle mid-scale tone and periodic underrun
    repeat (3) @(negedge clk);
    check("rst_sd_out", sd_out1, 0);
    check("rst_underrun", underrun1, 0);
    check("rst_overflow", overflow1, 0);
    check("rst_level", level1, 0);
    rst1 = 1'b0;
    first_unr = -1; unr = 0; ovf = 0;
    for (int k = 0; k < 96; k++) begin
      @(posedge clk); #1;
      if (k < 8) check($sformatf("idle_sd[%0d]", k), sd_out1, k % 2);
      if (underrun1) begin
        if (first_unr < 0) first_unr = k;
        unr++;
      end
      if (overflow1) ovf++;
    end
    check("idle_first_underrun", first_unr, 31);
    check("idle_underrun_count", unr, 3);
    check("idle_overflow_count", ovf, 0);

    // Single -4096 word: push latency, then a full hold period of zeros
    spi_if.nss = 1'b0;
    spi_word(13'h1000, 13, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (level1 == 3'd0) seen = 1'b1;
    end
    check("min_pop_seen", seen, 1);
    measure(ones);
    check("min_ones", ones, 0);
    end_frame();

    // Full-scale +4095 kept fed on the RATE=64 instance
    @(negedge clk);
    rst1 = 1'b1;
    rst2 = 1'b0;
    spi_if.nss = 1'b0;
    repeat (4) spi_word(13'h0FFF, 13, 1'b0);
    @(negedge clk);
    enable2 = 1'b1;
    ones = 0; unr = 0;
    fork
      repeat (170) spi_word(13'h0FFF, 13, 1'b0);
      begin
        repeat (100) @(posedge clk);
        repeat (8192) begin
          @(posedge clk); #1;
          ones += int'(sd_out2);
          if (underrun2) unr++;
        end
      end
    join
    end_frame();
    rst2 = 1'b1;
    enable2 = 1'b0;
    check("max_ones_8192", ones, 8191);
    check("max_underruns", unr, 0);

    // Six words while disabled: saturate, two overflows, FIFO order kept
    rst1 = 1'b0;
    reset_dut1();
    check("ovf_level_after_rst", level1, 0);
    spi_if.nss = 1'b0;
    for (int i = 0; i < 6; i++) spi_word(word_k(4 * (i + 1)), 13, 1'b0);
    end_frame();
    check("ovf_level_sat", level1, 4);
    check("ovf_pulses", ovf_cnt, 2);
    exp4 = '{4, 8, 12, 16};
    @(negedge clk);
    enable1 = 1'b1;
    repeat (32) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      measure(ones);
      check($sformatf("ovf_order[%0d]", i), ones, exp4[i]);
    end
    check("ovf_level_drained", level1, 0);

    // Partial word aborted by nss, then a clean 0x0ABC
    reset_dut1();
    spi_if.nss = 1'b0;
    spi_word(13'h1FFF, 7, 1'b0);
    end_frame();
    spi_if.nss = 1'b0;
    spi_word(13'h0ABC, 13, 1'b0);
    end_frame();
    check("abort_level", level1, 1);
    check("abort_overflow", ovf_cnt, 0);
    check("abort_underrun", unr_cnt, 0);
    @(negedge clk);
    enable1 = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    check("abort_popped", level1, 0);
    measure(ones);
    check("abort_word_density", (ones == 26 || ones == 27), 1);

    // Push into a full FIFO on the same edge as a pop
    reset_dut1();
    spi_if.nss = 1'b0;
    for (int i = 0; i < 4; i++) spi_word(word_k(4 * (i + 1)), 13, 1'b0);
    exp6 = '{4, 8, 12, 16, 28};
    fork
      spi_word(word_k(28), 13, 1'b0);
      begin
        repeat (22) @(negedge clk);
        enable1 = 1'b1;
        @(posedge clk);
        repeat (31) @(posedge clk);
        #1;
        check("race_level", level1, 4);
        for (int i = 0; i < 5; i++) begin
          measure(ones);
          check($sformatf("race_order[%0d]", i), ones, exp6[i]);
        end
      end
    join
    end_frame();
    check("race_overflow", ovf_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
